// File: rtl/pkt_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : pkt_pkg                                                 |
// | Desc    : Shared types and width defaults for the packet          |
// |           accumulator.                                            |
// | Rev     : 1.0  initial release                                    |
// +------------------------------------------------------------------+
package pkt_pkg;

  localparam int c_data_w_dflt = 32;
  localparam int c_len_w_dflt  = 4;

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_DATA = 2'd1,
    S_DROP = 2'd2,
    S_OUT  = 2'd3
  } pkt_state_t;

endpackage : pkt_pkg
`default_nettype wire

// File: rtl/pkt_accum.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : pkt_accum                                               |
// | Desc    : Parses a length header, sums the payload beats and      |
// |           reports length, sum and a framing error flag.          |
// | Rev     : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module pkt_accum
  import pkt_pkg::*;
#(
  parameter int DATA_W = c_data_w_dflt,
  parameter int LEN_W  = c_len_w_dflt
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LEN_W-1:0]  out_len,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_err
);

  pkt_state_t        r_state;
  pkt_state_t        w_state_nxt;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_sum;
  logic              r_err;

  logic              w_fire;
  logic [LEN_W-1:0]  w_hdr_len;
  logic              w_hdr_bad;
  logic [LEN_W:0]    w_cnt_inc;
  logic              w_cnt_hit;

  // in_ready is a pure function of state, so it never sees out_ready
  assign in_ready  = (r_state != S_OUT);
  assign out_valid = (r_state == S_OUT);
  assign out_len   = r_len;
  assign out_sum   = r_sum;
  assign out_err   = r_err;

  assign w_fire    = in_valid && in_ready;
  assign w_hdr_len = in_data[LEN_W-1:0];
  assign w_hdr_bad = (w_hdr_len == '0) || in_last;
  assign w_cnt_inc = {1'b0, r_cnt} + (LEN_W+1)'(1);
  assign w_cnt_hit = (w_cnt_inc == {1'b0, r_len});

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HDR: begin
        if (w_fire) begin
          if (w_hdr_bad) w_state_nxt = in_last ? S_OUT : S_DROP;
          else           w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_fire) begin
          if (in_last)        w_state_nxt = S_OUT;
          else if (w_cnt_hit) w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (w_fire && in_last) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        if (out_ready) w_state_nxt = S_HDR;
      end
      default: w_state_nxt = S_HDR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_HDR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Result registers double as the output holding registers in S_OUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len <= '0;
      r_cnt <= '0;
      r_sum <= '0;
      r_err <= 1'b0;
    end else if (w_fire) begin
      case (r_state)
        S_HDR: begin
          r_len <= w_hdr_len;
          r_cnt <= '0;
          r_sum <= '0;
          r_err <= w_hdr_bad;
        end
        S_DATA: begin
          r_sum <= r_sum + in_data;
          r_cnt <= w_cnt_inc[LEN_W-1:0];
          if (in_last)        r_err <= !w_cnt_hit;
          else if (w_cnt_hit) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule : pkt_accum
`default_nettype wire

// File: tb/tb_pkt_accum.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_pkt_accum                                            |
// | Desc    : Directed self-checking bench for pkt_accum.             |
// | Rev     : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module tb_pkt_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_len;
  logic [31:0] out_sum;
  logic        out_err;

  int n_checks = 0;
  int n_fails  = 0;

  pkt_accum #(.DATA_W(32), .LEN_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_len   (out_len),
    .out_sum   (out_sum),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one beat, hold it across one rising edge, sample 1 after
  task automatic beat(input logic [31:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic result(input string tag, input logic [3:0] l, input logic [31:0] s, input logic e);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_len"},   32'(out_len),   32'(l));
    chk({tag, "_sum"},   out_sum,        s);
    chk({tag, "_err"},   32'(out_err),   32'(e));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sum",   out_sum,        32'd0);
    chk("rst_len",   32'(out_len),   32'd0);
    chk("rst_err",   32'(out_err),   32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // len 3, upper header bits ignored
    beat(32'hABCD_0003, 1'b0);
    beat(32'h1, 1'b0);
    beat(32'h2, 1'b0);
    chk("t1_pre_valid", 32'(out_valid), 32'd0);
    beat(32'h3, 1'b1);
    result("t1", 4'd3, 32'h6, 1'b0);
    chk("t1_in_ready", 32'(in_ready), 32'd0);
    take();

    // wrap-around sum
    beat(32'h2, 1'b0);
    beat(32'hFFFF_FFFF, 1'b0);
    beat(32'h2, 1'b1);
    result("t2", 4'd2, 32'h1, 1'b0);
    take();

    // short packet
    beat(32'h4, 1'b0);
    beat(32'h5, 1'b0);
    beat(32'h7, 1'b1);
    result("t3", 4'd4, 32'hC, 1'b1);
    take();

    // zero length header, then drop two beats
    beat(32'h0, 1'b0);
    chk("t4_drop_valid", 32'(out_valid), 32'd0);
    beat(32'h11, 1'b0);
    beat(32'h22, 1'b1);
    result("t4", 4'd0, 32'h0, 1'b1);
    take();
    beat(32'h1, 1'b0);
    beat(32'h10, 1'b1);
    result("t4n", 4'd1, 32'h10, 1'b0);
    take();

    // long packet: extra beat discarded
    beat(32'h2, 1'b0);
    beat(32'h1, 1'b0);
    beat(32'h2, 1'b0);
    chk("t5_drop_valid", 32'(out_valid), 32'd0);
    beat(32'h100, 1'b1);
    result("t5", 4'd2, 32'h3, 1'b1);
    take();

    // header carrying in_last
    beat(32'h5, 1'b1);
    result("t6", 4'd5, 32'h0, 1'b1);
    take();

    // backpressure: stall 5 cycles while upstream offers a beat
    beat(32'h1, 1'b0);
    beat(32'h42, 1'b1);
    in_valid = 1'b1; in_data = 32'h99; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t7_hold_sum",   out_sum,          32'h42);
      chk("t7_hold_valid", 32'(out_valid),   32'd1);
      chk("t7_hold_ready", 32'(in_ready),    32'd0);
    end
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    result("t7", 4'd1, 32'h42, 1'b0);
    take();
    chk("t7_in_ready", 32'(in_ready), 32'd1);
    chk("t7_bubble",   32'(out_valid), 32'd0);

    // reset mid-packet
    beat(32'h3, 1'b0);
    beat(32'h1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t8_rst_sum",   out_sum,        32'd0);
    chk("t8_rst_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("t8_no_valid", 32'(out_valid), 32'd0);
    end
    beat(32'h1, 1'b0);
    beat(32'h9, 1'b1);
    result("t8", 4'd1, 32'h9, 1'b0);

    // reset while a result is pending
    #2 rst = 1'b1;
    #1;
    chk("t9_rst_valid", 32'(out_valid), 32'd0);
    chk("t9_rst_len",   32'(out_len),   32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("t9_in_ready", 32'(in_ready),  32'd1);
    chk("t9_valid",    32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_pkt_accum
`default_nettype wire
